// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUControl codes, MIPS opcode/funct fields and the
// issue-stage state encoding.
package alu_pkg;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluMul  = 4'b0010;
  localparam logic [3:0] AluBgez = 4'b0011;
  localparam logic [3:0] AluBgtz = 4'b0100;
  localparam logic [3:0] AluBlez = 4'b0101;
  localparam logic [3:0] AluBltz = 4'b0110;
  localparam logic [3:0] AluAnd  = 4'b0111;
  localparam logic [3:0] AluOr   = 4'b1000;
  localparam logic [3:0] AluNor  = 4'b1001;
  localparam logic [3:0] AluXor  = 4'b1010;
  localparam logic [3:0] AluSll  = 4'b1011;
  localparam logic [3:0] AluSrl  = 4'b1111;

  localparam logic [5:0] OpRtype    = 6'b000000;
  localparam logic [5:0] OpRegimm   = 6'b000001;
  localparam logic [5:0] OpBeq      = 6'b000100;
  localparam logic [5:0] OpBne      = 6'b000101;
  localparam logic [5:0] OpBlez     = 6'b000110;
  localparam logic [5:0] OpBgtz     = 6'b000111;
  localparam logic [5:0] OpAddi     = 6'b001000;
  localparam logic [5:0] OpSlti     = 6'b001010;
  localparam logic [5:0] OpAndi     = 6'b001100;
  localparam logic [5:0] OpOri      = 6'b001101;
  localparam logic [5:0] OpXori     = 6'b001110;
  localparam logic [5:0] OpSpecial2 = 6'b011100;
  localparam logic [5:0] OpLb       = 6'b100000;
  localparam logic [5:0] OpLh       = 6'b100001;
  localparam logic [5:0] OpLw       = 6'b100011;
  localparam logic [5:0] OpSb       = 6'b101000;
  localparam logic [5:0] OpSh       = 6'b101001;
  localparam logic [5:0] OpSw       = 6'b101011;

  localparam logic [5:0] FnSll = 6'b000000;
  localparam logic [5:0] FnSrl = 6'b000010;
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnXor = 6'b100110;
  localparam logic [5:0] FnNor = 6'b100111;
  localparam logic [5:0] FnSlt = 6'b101010;
  localparam logic [5:0] FnMul = 6'b000010;

  localparam logic [4:0] RtBltz = 5'b00000;
  localparam logic [4:0] RtBgez = 5'b00001;

  localparam logic [1:0] StEmpty   = 2'd0;
  localparam logic [1:0] StFull    = 2'd1;
  localparam logic [1:0] StMulWait = 2'd2;

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS instruction to ALUControl / operand-select decoder.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [3:0]  alu_ctrl_o,
  output logic        shamt_sel_o,
  output logic        imm_sel_o,
  output logic        illegal_o
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rt;
  logic       unused_bits;

  assign op = instr_i[31:26];
  assign fn = instr_i[5:0];
  assign rt = instr_i[20:16];
  assign unused_bits = ^{instr_i[25:21], instr_i[15:6]};

  always_comb begin
    alu_ctrl_o  = AluAdd;
    shamt_sel_o = 1'b0;
    imm_sel_o   = 1'b0;
    illegal_o   = 1'b0;
    case (op)
      OpRtype: begin
        case (fn)
          FnAdd:        alu_ctrl_o = AluAdd;
          FnSub, FnSlt: alu_ctrl_o = AluSub;
          FnAnd:        alu_ctrl_o = AluAnd;
          FnOr:         alu_ctrl_o = AluOr;
          FnNor:        alu_ctrl_o = AluNor;
          FnXor:        alu_ctrl_o = AluXor;
          FnSll: begin
            alu_ctrl_o  = AluSll;
            shamt_sel_o = 1'b1;
          end
          FnSrl: begin
            alu_ctrl_o  = AluSrl;
            shamt_sel_o = 1'b1;
          end
          default:      illegal_o = 1'b1;
        endcase
      end
      OpSpecial2: begin
        if (fn == FnMul) alu_ctrl_o = AluMul;
        else             illegal_o  = 1'b1;
      end
      OpAddi, OpLw, OpLh, OpLb, OpSw, OpSh, OpSb: begin
        alu_ctrl_o = AluAdd;
        imm_sel_o  = 1'b1;
      end
      OpSlti: begin
        alu_ctrl_o = AluSub;
        imm_sel_o  = 1'b1;
      end
      OpAndi: begin
        alu_ctrl_o = AluAnd;
        imm_sel_o  = 1'b1;
      end
      OpOri: begin
        alu_ctrl_o = AluOr;
        imm_sel_o  = 1'b1;
      end
      OpXori: begin
        alu_ctrl_o = AluXor;
        imm_sel_o  = 1'b1;
      end
      OpBeq, OpBne: alu_ctrl_o = AluSub;
      OpBgtz:       alu_ctrl_o = AluBgtz;
      OpBlez:       alu_ctrl_o = AluBlez;
      OpRegimm: begin
        if (rt == RtBgez)      alu_ctrl_o = AluBgez;
        else if (rt == RtBltz) alu_ctrl_o = AluBltz;
        else                   illegal_o  = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_control_stage.sv
// Registered ALU-control issue stage with valid/ready handshake towards EX and
// a multi-cycle hold for MUL.
module alu_control_stage
  import alu_pkg::*;
#(
  parameter int unsigned MulLatency = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        InValid,
  output logic        InReady,
  input  logic [31:0] Instruction,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [3:0]  ALUControl,
  output logic        ShamtSel,
  output logic        ImmSel,
  output logic        Illegal
);

  localparam int unsigned CntW    = (MulLatency > 1) ? $clog2(MulLatency) : 1;
  localparam int unsigned CntInit = (MulLatency > 1) ? MulLatency - 2 : 0;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      ctrl_q, ctrl_d;
  logic            shamt_q, shamt_d;
  logic            imm_q, imm_d;
  logic            ill_q, ill_d;

  logic [3:0] dec_ctrl;
  logic       dec_shamt;
  logic       dec_imm;
  logic       dec_ill;
  logic       accept;

  alu_decode u_decode (
    .instr_i     (Instruction),
    .alu_ctrl_o  (dec_ctrl),
    .shamt_sel_o (dec_shamt),
    .imm_sel_o   (dec_imm),
    .illegal_o   (dec_ill)
  );

  assign OutValid   = (state_q == StFull);
  assign InReady    = (state_q != StMulWait) && (!OutValid || OutReady);
  assign accept     = InValid && InReady;
  assign ALUControl = ctrl_q;
  assign ShamtSel   = shamt_q;
  assign ImmSel     = imm_q;
  assign Illegal    = ill_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    shamt_d = shamt_q;
    imm_d   = imm_q;
    ill_d   = ill_q;
    if (accept) begin
      ctrl_d  = dec_ctrl;
      shamt_d = dec_shamt;
      imm_d   = dec_imm;
      ill_d   = dec_ill;
      if (!dec_ill && dec_ctrl == AluMul && MulLatency > 1) begin
        state_d = StMulWait;
        cnt_d   = CntW'(CntInit);
      end else begin
        state_d = StFull;
      end
    end else begin
      case (state_q)
        StFull: begin
          if (OutReady) state_d = StEmpty;
        end
        StMulWait: begin
          if (cnt_q == '0) state_d = StFull;
          else             cnt_d   = cnt_q - CntW'(1);
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StEmpty;
      cnt_q   <= '0;
      ctrl_q  <= AluAdd;
      shamt_q <= 1'b0;
      imm_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      shamt_q <= shamt_d;
      imm_q   <= imm_d;
      ill_q   <= ill_d;
    end
  end

endmodule

// File: tb/tb_alu_control_stage.sv
// Self-checking bench for alu_control_stage: decode table through a scoreboard
// plus hand-written MUL, backpressure and reset-during-MUL sequences.
module tb_alu_control_stage;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       shamt;
    logic       imm;
    logic       ill;
  } exp_t;

  typedef struct packed {
    logic [31:0] instr;
    exp_t        exp;
  } vec_t;

  localparam int NV = 29;
  localparam logic [31:0] IAdd  = 32'h012A4020;
  localparam logic [31:0] ISub  = 32'h012A4022;
  localparam logic [31:0] IMul  = 32'h712A4002;
  localparam logic [31:0] IAddi = 32'h2128FFFF;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        InValid;
  logic        InReady;
  logic [31:0] Instruction;
  logic        OutValid;
  logic        OutReady;
  logic [3:0]  ALUControl;
  logic        ShamtSel;
  logic        ImmSel;
  logic        Illegal;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t cur_exp;
  exp_t sb_q[$];
  vec_t vec[NV];

  alu_control_stage #(.MulLatency(3)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .InValid     (InValid),
    .InReady     (InReady),
    .Instruction (Instruction),
    .OutValid    (OutValid),
    .OutReady    (OutReady),
    .ALUControl  (ALUControl),
    .ShamtSel    (ShamtSel),
    .ImmSel      (ImmSel),
    .Illegal     (Illegal)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard: pop on each consumed output, push on each accepted input.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (OutValid && OutReady) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: ctrl %h with empty scoreboard", ALUControl);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_ctrl", 32'(ALUControl), 32'(e.ctrl));
          check("sb_shamt", 32'(ShamtSel), 32'(e.shamt));
          check("sb_imm", 32'(ImmSel), 32'(e.imm));
          check("sb_illegal", 32'(Illegal), 32'(e.ill));
        end
      end
      if (InValid && InReady) sb_q.push_back(cur_exp);
    end
  end

  task automatic wait_accept();
    int cyc = 0;
    @(negedge Clk);
    while (!InReady && cyc < 20) begin
      @(negedge Clk);
      cyc++;
    end
    check("accept_within_bound", 32'(InReady), 32'd1);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    vec[0]  = '{IAdd,         '{4'b0000, 1'b0, 1'b0, 1'b0}};
    vec[1]  = '{ISub,         '{4'b0001, 1'b0, 1'b0, 1'b0}};
    vec[2]  = '{32'h012A402A, '{4'b0001, 1'b0, 1'b0, 1'b0}};
    vec[3]  = '{32'h012A4024, '{4'b0111, 1'b0, 1'b0, 1'b0}};
    vec[4]  = '{32'h012A4025, '{4'b1000, 1'b0, 1'b0, 1'b0}};
    vec[5]  = '{32'h012A4027, '{4'b1001, 1'b0, 1'b0, 1'b0}};
    vec[6]  = '{32'h012A4026, '{4'b1010, 1'b0, 1'b0, 1'b0}};
    vec[7]  = '{32'h00094080, '{4'b1011, 1'b1, 1'b0, 1'b0}};
    vec[8]  = '{32'h00094082, '{4'b1111, 1'b1, 1'b0, 1'b0}};
    vec[9]  = '{32'h00000000, '{4'b1011, 1'b1, 1'b0, 1'b0}};
    vec[10] = '{IMul,         '{4'b0010, 1'b0, 1'b0, 1'b0}};
    vec[11] = '{IAddi,        '{4'b0000, 1'b0, 1'b1, 1'b0}};
    vec[12] = '{32'h29280005, '{4'b0001, 1'b0, 1'b1, 1'b0}};
    vec[13] = '{32'h31280005, '{4'b0111, 1'b0, 1'b1, 1'b0}};
    vec[14] = '{32'h35280005, '{4'b1000, 1'b0, 1'b1, 1'b0}};
    vec[15] = '{32'h39280005, '{4'b1010, 1'b0, 1'b1, 1'b0}};
    vec[16] = '{32'h8D280004, '{4'b0000, 1'b0, 1'b1, 1'b0}};
    vec[17] = '{32'hA1280004, '{4'b0000, 1'b0, 1'b1, 1'b0}};
    vec[18] = '{32'h11280004, '{4'b0001, 1'b0, 1'b0, 1'b0}};
    vec[19] = '{32'h15280004, '{4'b0001, 1'b0, 1'b0, 1'b0}};
    vec[20] = '{32'h1D200004, '{4'b0100, 1'b0, 1'b0, 1'b0}};
    vec[21] = '{32'h19200004, '{4'b0101, 1'b0, 1'b0, 1'b0}};
    vec[22] = '{32'h05200004, '{4'b0110, 1'b0, 1'b0, 1'b0}};
    vec[23] = '{32'h05210004, '{4'b0011, 1'b0, 1'b0, 1'b0}};
    vec[24] = '{32'h08000010, '{4'b0000, 1'b0, 1'b0, 1'b1}};
    vec[25] = '{32'h05220004, '{4'b0000, 1'b0, 1'b0, 1'b1}};
    vec[26] = '{32'h01200008, '{4'b0000, 1'b0, 1'b0, 1'b1}};
    vec[27] = '{32'h712A4000, '{4'b0000, 1'b0, 1'b0, 1'b1}};
    vec[28] = '{IAdd,         '{4'b0000, 1'b0, 1'b0, 1'b0}};

    Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0; Instruction = '0; cur_exp = '0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    check("rst_outvalid", 32'(OutValid), 32'd0);
    check("rst_inready", 32'(InReady), 32'd1);
    check("rst_ctrl", 32'(ALUControl), 32'd0);
    check("rst_shamt", 32'(ShamtSel), 32'd0);
    check("rst_imm", 32'(ImmSel), 32'd0);
    check("rst_illegal", 32'(Illegal), 32'd0);

    // Decode table, back to back with EX always ready.
    @(posedge Clk); #1;
    OutReady = 1'b1;
    for (int i = 0; i < NV; i++) begin
      Instruction = vec[i].instr;
      cur_exp     = vec[i].exp;
      InValid     = 1'b1;
      wait_accept();
    end
    InValid = 1'b0;
    repeat (3) @(posedge Clk);
    #1;

    // MUL hold: addi offered right after MUL must wait for OutValid.
    Instruction = IMul; cur_exp = '{4'b0010, 1'b0, 1'b0, 1'b0}; InValid = 1'b1;
    @(negedge Clk);
    check("mul_inready_before", 32'(InReady), 32'd1);
    @(posedge Clk); #1;
    Instruction = IAddi; cur_exp = '{4'b0000, 1'b0, 1'b1, 1'b0};
    @(negedge Clk);
    check("mul_ctrl_early", 32'(ALUControl), 32'h2);
    check("mul_outvalid_w1", 32'(OutValid), 32'd0);
    check("mul_inready_w1", 32'(InReady), 32'd0);
    @(negedge Clk);
    check("mul_outvalid_w2", 32'(OutValid), 32'd0);
    check("mul_inready_w2", 32'(InReady), 32'd0);
    @(negedge Clk);
    check("mul_outvalid_done", 32'(OutValid), 32'd1);
    check("mul_inready_done", 32'(InReady), 32'd1);
    @(posedge Clk); #1;
    InValid = 1'b0;
    @(negedge Clk);
    check("addi_ctrl", 32'(ALUControl), 32'h0);
    check("addi_imm", 32'(ImmSel), 32'd1);
    check("addi_outvalid", 32'(OutValid), 32'd1);

    // Backpressure: outputs frozen, pending sub loads when OutReady rises.
    @(posedge Clk); #1;
    Instruction = IAdd; cur_exp = '{4'b0000, 1'b0, 1'b0, 1'b0}; InValid = 1'b1;
    @(posedge Clk); #1;
    OutReady = 1'b0;
    Instruction = ISub; cur_exp = '{4'b0001, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("bp_inready", 32'(InReady), 32'd0);
      check("bp_outvalid", 32'(OutValid), 32'd1);
      check("bp_ctrl_frozen", 32'(ALUControl), 32'h0);
    end
    @(posedge Clk); #1;
    OutReady = 1'b1;
    @(negedge Clk);
    check("bp_inready_release", 32'(InReady), 32'd1);
    @(posedge Clk); #1;
    InValid = 1'b0;
    @(negedge Clk);
    check("bp_sub_loaded", 32'(ALUControl), 32'h1);
    check("bp_sub_valid", 32'(OutValid), 32'd1);

    // Reset in the second MUL_WAIT cycle, held over an offered add.
    @(posedge Clk); #1;
    Instruction = IMul; cur_exp = '{4'b0010, 1'b0, 1'b0, 1'b0}; InValid = 1'b1;
    @(posedge Clk); #1;
    InValid = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b1; InValid = 1'b1; Instruction = IAdd;
    sb_q.delete();
    @(negedge Clk);
    check("rw_wait_outvalid", 32'(OutValid), 32'd0);
    @(negedge Clk);
    check("rw_outvalid", 32'(OutValid), 32'd0);
    check("rw_ctrl", 32'(ALUControl), 32'h0);
    check("rw_shamt", 32'(ShamtSel), 32'd0);
    check("rw_imm", 32'(ImmSel), 32'd0);
    check("rw_illegal", 32'(Illegal), 32'd0);
    check("rw_inready", 32'(InReady), 32'd1);
    @(posedge Clk); #1;
    Reset = 1'b0; InValid = 1'b0;
    @(negedge Clk);
    check("rw_accept_overridden", 32'(OutValid), 32'd0);
    @(negedge Clk);
    check("rw_no_spurious_valid", 32'(OutValid), 32'd0);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge Clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_control_stage.md
# alu_control_stage

Registered ALU-control issue stage between instruction decode and the 32-bit ALU in the MIPS datapath. It decodes a 32-bit instruction into the 4-bit ALUControl code the ALU consumes, plus operand-select flags, and presents them to EX through a valid/ready handshake. For MUL it also sequences a multi-cycle hold, keeping the code stable and withholding OutValid until the multiply latency has elapsed.

## Interface
- MulLatency, 3: EX cycles a MUL needs, ≥1.
- Clk  in  1  clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high.
- InValid  in  1  Instruction is valid this cycle.
- InReady  out  1  stage accepts Instruction this cycle; combinational.
- Instruction  in  32  MIPS instruction word.
- OutValid  out  1  registered outputs are valid for EX.
- OutReady  in  1  EX consumes the current output this cycle.
- ALUControl  out  4  ALU operation code.
- ShamtSel  out  1  ALU B operand comes from Instruction[10:6].
- ImmSel  out  1  ALU B operand comes from the immediate.
- Illegal  out  1  registered instruction was not decodable.

## Operation
- ALUControl codes (fixed): ADD 0000, SUB 0001, MUL 0010, BGEZ 0011, BGTZ 0100, BLEZ 0101, BLTZ 0110, AND 0111, OR 1000, NOR 1001, XOR 1010, SLL 1011, SRL 1111. Codes 1100–1110 are never driven.
- Decode, with op = [31:26], fn = [5:0], rt = [20:16]:
  - op 000000 R-type: fn 100000→ADD; 100010→SUB; 101010 (slt)→SUB; 100100→AND; 100101→OR; 100111→NOR; 100110→XOR; 000000→SLL with ShamtSel=1; 000010→SRL with ShamtSel=1.
  - op 011100, fn 000010 → MUL.
  - Immediate forms, all with ImmSel=1: addi 001000→ADD; slti 001010→SUB; andi 001100→AND; ori 001101→OR; xori 001110→XOR.
  - Loads and stores, all ADD with ImmSel=1: lw 100011, lh 100001, lb 100000, sw 101011, sh 101001, sb 101000.
  - beq 000100 and bne 000101 → SUB.
  - bgtz 000111→BGTZ; blez 000110→BLEZ.
  - op 000001: rt 00001→BGEZ; rt 00000→BLTZ.
- Anything else: Illegal=1, ALUControl=ADD, ShamtSel=0, ImmSel=0. The word still travels through the handshake.
- Instruction 0x00000000 (nop) decodes as SLL with ShamtSel=1. It is legal.
- States:
  - EMPTY: OutValid=0.
  - FULL: OutValid=1.
  - MUL_WAIT: OutValid=0. The MUL code is already driven on ALUControl.
- InReady = (state≠MUL_WAIT) && (!OutValid || OutReady).
- Accept = InValid && InReady. On accept, the decoded fields load into the output registers.
- Transitions:
  - EMPTY, accept of non-MUL → FULL.
  - EMPTY, accept of MUL with MulLatency>1 → MUL_WAIT, counter = MulLatency−2. With MulLatency=1 → FULL directly.
  - FULL, OutReady with accept → reload, using the same rules as from EMPTY.
  - FULL, OutReady without accept → EMPTY. Output fields hold their last value.
  - FULL, !OutReady → hold. Outputs must stay stable.
  - MUL_WAIT: counter decrements each cycle. When the counter is 0 → FULL.
- Reset in any state, MUL_WAIT included: state EMPTY, counter 0, OutValid 0, ALUControl 0000, ShamtSel 0, ImmSel 0, Illegal 0. Reset overrides a same-cycle accept. InReady=1 in the first cycle after reset.

## Timing
- Latency is 1 cycle for non-MUL: accept at edge N, OutValid=1 after edge N.
- MUL: accept at edge N. ALUControl=0010 after edge N. OutValid=1 after edge N+MulLatency−1.
- Throughput is 1 instruction/cycle when OutReady is held high. A MUL blocks input for MulLatency−1 cycles.
- No combinational path from Instruction to any output. The only combinational path is OutReady→InReady.
- Counter width: $clog2(MulLatency) bits, minimum 1.

## Structure
- Shared package alu_pkg holds:
  - the 4-bit ALUControl code constants;
  - the opcode and funct constants;
  - the state enum.
  The ALU itself uses the same package.
- One sub-module, alu_decode: purely combinational. It maps Instruction to {ALUControl, ShamtSel, ImmSel, Illegal}.
- The top level holds the state machine, the counter and the output registers.

## Test plan
- Reset, then add 0x012A4020 with OutReady=1 → one cycle later OutValid=1, ALUControl=0000, ImmSel=0, ShamtSel=0.
- mul 0x712A4002, MulLatency=3 → ALUControl=0010 next cycle, OutValid=0 for 2 cycles then 1, InReady=0 during the wait. A following addi 0x2128FFFF is accepted only after OutValid rises, and gives 0000 with ImmSel=1.
- sll 0x00094080 → 1011 with ShamtSel=1. bltz 0x05200004 → 0110. bgez 0x05210004 → 0011. blez 0x19200004 → 0101.
- j 0x08000010 → Illegal=1, ALUControl=0000. The next legal instruction clears Illegal.
- Backpressure: OutReady=0 for 4 cycles with InValid=1 → InReady=0 and outputs frozen. When OutReady rises, the pending instruction loads on that edge.
- Reset asserted in the 2nd cycle of MUL_WAIT → all outputs take their reset values next cycle, with no spurious OutValid.
